prbs4_checker: RTL and testbench

PRBS4_CHECKER -- requirements
Module: prbs4_checker

---
 rtl/prbs4_checker.sv | 130 +++++++++++++
 tb/tb_prbs4_checker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs4_checker.sv
// PRBS4 (x^4+x^3+1) receive checker with lock tracking.
// Counts bit errors seen while locked into a saturating counter.
module prbs4_checker #(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic             zero_flag
);

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;

    localparam logic [7:0]       LOCK_C   = 8'(LOCK_CNT);
    localparam logic [7:0]       UNLOCK_C = 8'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] ERR_MAX  = '1;

    logic [1:0]       state_q, state_d;
    logic [3:0]       h_q, h_d;
    logic [2:0]       fill_q, fill_d;
    logic [7:0]       match_q, match_d;
    logic [7:0]       miss_q, miss_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             pulse_q, pulse_d;

    logic       checked;
    logic       exp_bit;
    logic       match;
    logic [7:0] match_inc;
    logic [7:0] miss_inc;

    assign exp_bit   = h_q[2] ^ h_q[3];
    assign checked   = din_valid && (fill_q == 3'd4);
    // An all-zero history is the LFSR lock-up state, never a valid match.
    assign match     = (din == exp_bit) && (h_q != 4'b0000);
    assign match_inc = match_q + 8'd1;
    assign miss_inc  = miss_q + 8'd1;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = err_q;
        pulse_d = 1'b0;

        if (din_valid) begin
            h_d = {h_q[2:0], din};
            if (fill_q != 3'd4) begin
                fill_d = fill_q + 3'd1;
            end
            if (state_q == S_FILL && fill_q == 3'd3) begin
                state_d = S_SYNC;
            end
        end

        if (checked) begin
            unique case (1'b1)
                (state_q == S_SYNC): begin
                    if (!match) begin
                        match_d = '0;
                    end else if (match_inc == LOCK_C) begin
                        state_d = S_LOCK;
                        match_d = '0;
                    end else begin
                        match_d = match_inc;
                    end
                end
                (state_q == S_LOCK): begin
                    if (match) begin
                        miss_d = '0;
                    end else begin
                        pulse_d = 1'b1;
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 1'b1;
                        end
                        if (miss_inc == UNLOCK_C) begin
                            state_d = S_SYNC;
                            miss_d  = '0;
                            match_d = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (clr_err) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FILL;
            h_q     <= 4'b0000;
            fill_q  <= '0;
            match_q <= '0;
            miss_q  <= '0;
            err_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
        end
    end

    assign locked    = (state_q == S_LOCK);
    assign err_pulse = pulse_q;
    assign err_cnt   = err_q;
    assign zero_flag = (h_q == 4'b0000);

endmodule

// File: tb/tb_prbs4_checker.sv
// Bench for prbs4_checker: vector table, directed corner cases and
// randomized traffic against a bit-history reference model.
module tb_prbs4_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;
    logic        clr_err = 1'b0;
    logic        locked, err_pulse, zero_flag;
    logic [15:0] err_cnt;
    logic        locked_s, err_pulse_s, zero_flag_s;
    logic [1:0]  err_cnt_s;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prbs4_checker u_dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .zero_flag(zero_flag)
    );

    prbs4_checker #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .clr_err(clr_err), .locked(locked_s), .err_pulse(err_pulse_s),
        .err_cnt(err_cnt_s), .zero_flag(zero_flag_s)
    );

    // Reference model: last received bits, mode (0 fill, 1 sync, 2 locked),
    // run lengths, and an unbounded error tally clipped per counter width.
    int m_h[$];
    int m_st, m_nv, m_run, m_miss, m_err;
    bit m_pulse;

    function automatic void m_reset();
        m_h.delete();
        m_st = 0; m_nv = 0; m_run = 0; m_miss = 0; m_err = 0;
        m_pulse = 1'b0;
    endfunction

    function automatic bit m_zero();
        foreach (m_h[i]) if (m_h[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_step(bit v, bit d, bit c);
        bit ok;
        m_pulse = 1'b0;
        if (v) begin
            if (m_nv >= 4) begin
                ok = (d == (m_h[0] ^ m_h[1])) && !m_zero();
                if (m_st == 1) begin
                    if (ok) begin
                        m_run++;
                        if (m_run == 8) begin m_st = 2; m_run = 0; end
                    end else m_run = 0;
                end else if (m_st == 2) begin
                    if (ok) m_miss = 0;
                    else begin
                        m_pulse = 1'b1;
                        m_err++;
                        m_miss++;
                        if (m_miss == 4) begin
                            m_st = 1; m_miss = 0; m_run = 0;
                        end
                    end
                end
            end
            m_h.push_back(int'(d));
            if (m_h.size() > 4) void'(m_h.pop_front());
            if (m_nv < 4) m_nv++;
            if (m_nv == 4 && m_st == 0) m_st = 1;
        end
        if (c) m_err = 0;
    endfunction

    // Transmit-side generator of the clean PRBS4 sequence, seeded 1,1,1,1.
    int g_q[$];

    function automatic bit gen_bit();
        bit b;
        if (g_q.size() < 4) b = 1'b1;
        else b = bit'(g_q[0] ^ g_q[1]);
        g_q.push_back(int'(b));
        if (g_q.size() > 4) void'(g_q.pop_front());
        return b;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int e16, e2;
        e16 = (m_err > 65535) ? 65535 : m_err;
        e2  = (m_err > 3) ? 3 : m_err;
        chk("locked", int'(locked), int'(m_st == 2));
        chk("err_pulse", int'(err_pulse), int'(m_pulse));
        chk("err_cnt", int'(err_cnt), e16);
        chk("zero_flag", int'(zero_flag), int'(m_zero()));
        chk("sat_locked", int'(locked_s), int'(m_st == 2));
        chk("sat_err_pulse", int'(err_pulse_s), int'(m_pulse));
        chk("sat_err_cnt", int'(err_cnt_s), e2);
        chk("sat_zero_flag", int'(zero_flag_s), int'(m_zero()));
    endtask

    task automatic cyc(input bit v, input bit d, input bit c);
        @(negedge clk);
        din_valid = v; din = d; clr_err = c;
        @(posedge clk);
        if (rst) m_step(v, d, c);
        else m_reset();
        #1;
        check_all();
    endtask

    task automatic send(input bit flip);
        cyc(1'b1, gen_bit() ^ flip, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; din_valid = 1'b0; din = 1'b0; clr_err = 1'b0;
        m_reset();
        g_q.delete();
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_pulse", int'(err_pulse), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_zero_flag", int'(zero_flag), 1);
        chk("rst_sat_err_cnt", int'(err_cnt_s), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        bit v; bit d; bit c;
        bit lk; bit pl; int er; bit zf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit v, bit d, bit c,
                                bit lk, bit pl, int er, bit zf);
        vec_t t;
        t.v = v; t.d = d; t.c = c;
        t.lk = lk; t.pl = pl; t.er = er; t.zf = zf;
        tbl.push_back(t);
    endfunction

    initial begin
        bit seen_lock;
        bit clean[12];
        bit fd;

        clean = '{1,1,1,1,0,0,0,1,0,0,1,1};
        for (int i = 0; i < 12; i++) add(1, clean[i], 0, i == 11, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 1, 1, 0);   // b13 inverted
        add(0, 0, 0, 1, 0, 1, 0);
        add(1, 1, 0, 1, 0, 1, 0);
        add(1, 0, 0, 1, 0, 1, 0);
        add(1, 1, 0, 1, 1, 2, 0);   // echo of b13 via tap n-3
        add(1, 1, 0, 1, 1, 3, 0);   // echo of b13 via tap n-4
        add(1, 1, 0, 1, 0, 3, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 1, 1, 0, 0);   // error coincident with clear

        do_reset();
        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].c);
            chk($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].lk));
            chk($sformatf("tbl%0d_pulse", i), int'(err_pulse), int'(tbl[i].pl));
            chk($sformatf("tbl%0d_err", i), int'(err_cnt), tbl[i].er);
            chk($sformatf("tbl%0d_zero", i), int'(zero_flag), int'(tbl[i].zf));
            chk($sformatf("tbl%0d_sat_err", i), int'(err_cnt_s), tbl[i].er);
        end

        // Sustained errors drop lock; original stream then relocks.
        do_reset();
        repeat (12) send(1'b0);
        chk("sus_locked_pre", int'(locked), 1);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            fd = (m_h[0] ^ m_h[1]) ? 1'b0 : 1'b1;
            void'(gen_bit());
            cyc(1'b1, fd, 1'b0);
            if (i == 2) chk("sus_locked_3", int'(locked), 1);
        end
        chk("sus_locked_4", int'(locked), 0);
        chk("sus_err_cnt", int'(err_cnt), 4);
        repeat (12) send(1'b0);
        chk("sus_relock", int'(locked), 1);

        // All-zero stream never locks.
        do_reset();
        seen_lock = 1'b0;
        repeat (50) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (locked) seen_lock = 1'b1;
        end
        chk("zero_flag_50", int'(zero_flag), 1);
        chk("zero_never_locked", int'(seen_lock), 0);
        chk("zero_err_cnt", int'(err_cnt), 0);

        // Gapped stream locks on the same valid-bit count.
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            send(1'b0);
            if (i == 11) chk("gap_locked_11", int'(locked), 0);
            if (i == 12) chk("gap_locked_12", int'(locked), 1);
            cyc(1'b0, 1'b0, 1'b0);
            if (i == 12) chk("gap_locked_hold", int'(locked), 1);
        end

        // Two isolated flips give six errors; 2-bit counter saturates.
        do_reset();
        repeat (12) send(1'b0);
        repeat (2) begin
            send(1'b1);
            repeat (7) send(1'b0);
        end
        chk("sat_main_err", int'(err_cnt), 6);
        chk("sat_small_err", int'(err_cnt_s), 3);
        chk("sat_still_locked", int'(locked), 1);

        // Asynchronous reset while locked.
        do_reset();
        repeat (12) send(1'b0);
        chk("mr_locked_pre", int'(locked), 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        din_valid = 1'b1;
        #1;
        chk("mr_async_locked", int'(locked), 0);
        chk("mr_async_zero", int'(zero_flag), 1);
        chk("mr_async_sat_locked", int'(locked_s), 0);
        m_reset();
        g_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        rst = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            send(1'b0);
            if (i == 11) chk("mr_locked_11", int'(locked), 0);
        end
        chk("mr_relock_12", int'(locked), 1);

        // Randomized traffic with gaps, flips, bursts and clears.
        do_reset();
        repeat (2000) begin
            if ($urandom_range(0, 149) == 0) begin
                repeat (4) send(1'b1);
            end else if ($urandom_range(0, 3) != 0) begin
                cyc(1'b1, gen_bit() ^ ($urandom_range(0, 24) == 0),
                    $urandom_range(0, 40) == 0);
            end else begin
                cyc(1'b0, 1'b0, $urandom_range(0, 40) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
